// File: rtl/sha256_digest_reader_if.sv
// Word-stream handshake between the digest reader and a word-wide sink.
// The master drives the word, its index and the last flag; the slave
// drives back-pressure.
interface sha256_digest_reader_if #(
  parameter int WORD_BITS = 32
);
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_BITS-1:0] out_data;
  logic [2:0]           out_index;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sha256_digest_reader.sv
// SHA-256 digest reader: captures the core's digest on trigger and streams it
// out H0 first as NUM_WORDS words over valid/ready. A one-deep pending buffer
// absorbs a digest that arrives while another is streaming; a digest that
// finds both registers occupied is dropped and flagged in sticky overflow.
module sha256_digest_reader #(
  parameter  int WORD_BITS   = 32,
  parameter  int DIGEST_BITS = 256,
  localparam int NUM_WORDS   = DIGEST_BITS / WORD_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trigger,
  input  logic [DIGEST_BITS-1:0] H_in,
  sha256_digest_reader_if.master out_if,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            digest_count
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [DIGEST_BITS-1:0] active_reg, active_next;
  logic [DIGEST_BITS-1:0] pending_reg, pending_next;
  logic                   p_full_reg, p_full_next;
  logic [2:0]             idx_reg, idx_next;
  logic                   overflow_reg, overflow_next;
  logic [15:0]            count_reg, count_next;

  logic                   sending;
  logic                   beat;
  logic                   final_beat;

  // Active register sliced into words, H0 (the most significant) at index 0.
  logic [WORD_BITS-1:0]   words [NUM_WORDS];

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign words[gi] = active_reg[DIGEST_BITS-1-WORD_BITS*gi -: WORD_BITS];
    end
  endgenerate

  assign sending    = (state_reg == SEND);
  assign beat       = sending && out_if.out_ready;
  assign final_beat = beat && (idx_reg == LAST_IDX);

  // Outputs decode registers only; out_ready and trigger never reach them
  // combinationally, so the word is stable for the whole of a stall.
  assign out_if.out_valid = sending;
  assign out_if.out_data  = words[idx_reg];
  assign out_if.out_index = idx_reg;
  assign out_if.out_last  = sending && (idx_reg == LAST_IDX);
  assign busy             = sending || p_full_reg;
  assign overflow         = overflow_reg;
  assign digest_count     = count_reg;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      active_reg   <= '0;
      pending_reg  <= '0;
      p_full_reg   <= 1'b0;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      active_reg   <= active_next;
      pending_reg  <= pending_next;
      p_full_reg   <= p_full_next;
      idx_reg      <= idx_next;
      overflow_reg <= overflow_next;
      count_reg    <= count_next;
    end
  end

  // Next-state logic: capture, word advance, pending hand-over and drops.
  always_comb begin
    state_next    = state_reg;
    active_next   = active_reg;
    pending_next  = pending_reg;
    p_full_next   = p_full_reg;
    idx_next      = idx_reg;
    overflow_next = overflow_reg;
    count_next    = count_reg;

    unique case (state_reg)
      IDLE: begin
        // The pending buffer is always empty here, so a capture goes
        // straight into the active register.
        if (trigger) begin
          active_next = H_in;
          idx_next    = '0;
          state_next  = SEND;
        end
      end

      SEND: begin
        if (final_beat) begin
          count_next = count_reg + 16'd1;
          idx_next   = '0;
          if (p_full_reg) begin
            // Pending digest goes next; a coincident trigger refills the
            // slot it just vacated, so nothing is lost.
            active_next = pending_reg;
            if (trigger) begin
              pending_next = H_in;
            end else begin
              p_full_next  = 1'b0;
            end
          end else if (trigger) begin
            // Back-to-back with no idle cycle.
            active_next = H_in;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (beat) begin
            idx_next = idx_reg + 3'd1;
          end
          if (trigger) begin
            if (!p_full_reg) begin
              pending_next = H_in;
              p_full_next  = 1'b1;
            end else begin
              overflow_next = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
